// File: rtl/can_error_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : can_error_frame_ctrl
// Description : CAN error-frame sequencer. Drives the error flag (active or
//               passive), tolerates dominant superposition, checks the error
//               delimiter, then waits out the intermission. Also runs bus-off
//               recovery (RECOV_SEQ x RECOV_BITS recessive bits).
// Ports       : clk, rst (async, active-high)
//               sample_tick/rx_bit      - bit-sample strobe and bus level
//               error_frame_req         - level request (sampled in IDLE)
//               error_passive, bus_off  - node error state
//               tx_drive/tx_bit         - TX mux ownership and driven bit
//               error_frame_sent, form_err_delim, stuck_dominant,
//               recovery_done           - one-clk status pulses
//               busy                    - sequencer not idle
//               err_frame_cnt           - sent-frame counter
// Options     : define ERR_FRAME_STATS_EN to build the saturating
//               err_frame_cnt counter; otherwise it is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module can_error_frame_ctrl #(
  parameter int FLAG_LEN     = 6,
  parameter int DELIM_LEN    = 8,
  parameter int IFS_LEN      = 3,
  parameter int SUPERPOS_MAX = 14,
  parameter int RECOV_SEQ    = 128,
  parameter int RECOV_BITS   = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_tick,
  input  logic        rx_bit,
  input  logic        error_frame_req,
  input  logic        error_passive,
  input  logic        bus_off,
  output logic        tx_drive,
  output logic        tx_bit,
  output logic        error_frame_sent,
  output logic        form_err_delim,
  output logic        stuck_dominant,
  output logic        recovery_done,
  output logic        busy,
  output logic [15:0] err_frame_cnt
);

  // One shared bit counter serves the flag, delimiter and intermission.
  localparam int BIT_MAX0 = (FLAG_LEN > DELIM_LEN) ? FLAG_LEN : DELIM_LEN;
  localparam int BIT_MAX  = (BIT_MAX0 > IFS_LEN) ? BIT_MAX0 : IFS_LEN;
  localparam int BW = $clog2(BIT_MAX + 1);
  localparam int DW = $clog2(SUPERPOS_MAX + 1);
  localparam int RW = $clog2(RECOV_BITS + 1);
  localparam int SW = $clog2(RECOV_SEQ + 1);

  localparam logic [BW-1:0] C_FLAG_LEN  = BW'(FLAG_LEN);
  localparam logic [BW-1:0] C_DELIM_LEN = BW'(DELIM_LEN);
  localparam logic [BW-1:0] C_IFS_LEN   = BW'(IFS_LEN);
  localparam logic [DW-1:0] C_SUP_MAX   = DW'(SUPERPOS_MAX);
  localparam logic [RW-1:0] C_REC_BITS  = RW'(RECOV_BITS);
  localparam logic [SW-1:0] C_REC_SEQ   = SW'(RECOV_SEQ);

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_FLAG         = 3'd1,
    S_SUPERPOS     = 3'd2,
    S_DELIM        = 3'd3,
    S_INTERMISSION = 3'd4,
    S_BUS_OFF      = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [DW-1:0] dom_cnt_q, dom_cnt_d;
  logic [RW-1:0] rec_cnt_q, rec_cnt_d;
  logic [SW-1:0] seq_cnt_q, seq_cnt_d;
  logic          mode_p_q, mode_p_d;
  logic          last_rx_q, last_rx_d;
  logic          sent_q, sent_d;
  logic          ferr_q, ferr_d;
  logic          stuck_q, stuck_d;
  logic          recov_q, recov_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      dom_cnt_q <= '0;
      rec_cnt_q <= '0;
      seq_cnt_q <= '0;
      mode_p_q  <= 1'b0;
      last_rx_q <= 1'b1;
      sent_q    <= 1'b0;
      ferr_q    <= 1'b0;
      stuck_q   <= 1'b0;
      recov_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      dom_cnt_q <= dom_cnt_d;
      rec_cnt_q <= rec_cnt_d;
      seq_cnt_q <= seq_cnt_d;
      mode_p_q  <= mode_p_d;
      last_rx_q <= last_rx_d;
      sent_q    <= sent_d;
      ferr_q    <= ferr_d;
      stuck_q   <= stuck_d;
      recov_q   <= recov_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    dom_cnt_d = dom_cnt_q;
    rec_cnt_d = rec_cnt_q;
    seq_cnt_d = seq_cnt_q;
    mode_p_d  = mode_p_q;
    last_rx_d = last_rx_q;
    sent_d    = 1'b0;
    ferr_d    = 1'b0;
    stuck_d   = 1'b0;
    recov_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        bit_cnt_d = '0;
        dom_cnt_d = '0;
        if (!bus_off && error_frame_req) begin
          state_d  = S_FLAG;
          mode_p_d = error_passive;
        end
      end

      S_FLAG: begin
        if (sample_tick) begin
          last_rx_d = rx_bit;
          // Passive flag: restart the run on a level change (first tick is 1).
          if (mode_p_q && (bit_cnt_q != '0) && (rx_bit != last_rx_q))
            bit_cnt_d = BW'(1);
          else
            bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_d == C_FLAG_LEN) begin
            state_d   = S_SUPERPOS;
            bit_cnt_d = '0;
            dom_cnt_d = '0;
          end
        end
      end

      S_SUPERPOS: begin
        if (sample_tick) begin
          if (!rx_bit) begin
            dom_cnt_d = dom_cnt_q + 1'b1;
            if (dom_cnt_d == C_SUP_MAX) begin
              stuck_d   = 1'b1;
              dom_cnt_d = '0;
            end
          end else begin
            // This recessive bit is already delimiter bit 1.
            state_d   = S_DELIM;
            bit_cnt_d = BW'(1);
          end
        end
      end

      S_DELIM: begin
        if (sample_tick) begin
          if (rx_bit) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_d == C_DELIM_LEN) begin
              sent_d    = 1'b1;
              state_d   = S_INTERMISSION;
              bit_cnt_d = '0;
            end
          end else begin
            ferr_d    = 1'b1;
            mode_p_d  = error_passive;
            state_d   = S_FLAG;
            bit_cnt_d = '0;
            dom_cnt_d = '0;
          end
        end
      end

      S_INTERMISSION: begin
        // Bus level is ignored: a dominant bit does not shorten this phase.
        if (sample_tick) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_d == C_IFS_LEN) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
          end
        end
      end

      S_BUS_OFF: begin
        if (!bus_off) begin
          state_d   = S_IDLE;
          rec_cnt_d = '0;
          seq_cnt_d = '0;
        end else if (sample_tick) begin
          if (!rx_bit) begin
            rec_cnt_d = '0;
          end else if ((rec_cnt_q + 1'b1) == C_REC_BITS) begin
            rec_cnt_d = '0;
            seq_cnt_d = seq_cnt_q + 1'b1;
            if (seq_cnt_d == C_REC_SEQ) begin
              recov_d   = 1'b1;
              state_d   = S_IDLE;
              seq_cnt_d = '0;
            end
          end else begin
            rec_cnt_d = rec_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Bus-off overrides everything; only a coincident error_frame_sent
    // survives so the error-counter block still sees its request served.
    if (bus_off && (state_q != S_BUS_OFF)) begin
      state_d   = S_BUS_OFF;
      bit_cnt_d = '0;
      dom_cnt_d = '0;
      rec_cnt_d = '0;
      seq_cnt_d = '0;
      ferr_d    = 1'b0;
      stuck_d   = 1'b0;
      recov_d   = 1'b0;
    end
  end

  assign tx_drive         = (state_q == S_FLAG) || (state_q == S_SUPERPOS) ||
                            (state_q == S_DELIM);
  assign tx_bit           = !((state_q == S_FLAG) && !mode_p_q);
  assign busy             = (state_q != S_IDLE);
  assign error_frame_sent = sent_q;
  assign form_err_delim   = ferr_q;
  assign stuck_dominant   = stuck_q;
  assign recovery_done    = recov_q;

`ifdef ERR_FRAME_STATS_EN
  logic [15:0] frame_cnt_q;

  // Counts on sent_d so the count is visible together with the pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      frame_cnt_q <= '0;
    else if (sent_d && (frame_cnt_q != 16'hFFFF))
      frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign err_frame_cnt = frame_cnt_q;
`else
  assign err_frame_cnt = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_can_error_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_can_error_frame_ctrl
// Description : Self-checking bench for can_error_frame_ctrl. Scenario-level
//               reference: each error frame is built from its flag,
//               superposition, delimiter and intermission phases and the
//               expected outputs follow from the phase and bit position.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_can_error_frame_ctrl;

  localparam int FLAG_LEN     = 6;
  localparam int DELIM_LEN    = 8;
  localparam int IFS_LEN      = 3;
  localparam int SUPERPOS_MAX = 14;
  localparam int RECOV_SEQ    = 128;
  localparam int RECOV_BITS   = 11;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_tick;
  logic        rx_bit;
  logic        error_frame_req;
  logic        error_passive;
  logic        bus_off;
  logic        tx_drive;
  logic        tx_bit;
  logic        error_frame_sent;
  logic        form_err_delim;
  logic        stuck_dominant;
  logic        recovery_done;
  logic        busy;
  logic [15:0] err_frame_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int frames   = 0;

  can_error_frame_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .sample_tick      (sample_tick),
    .rx_bit           (rx_bit),
    .error_frame_req  (error_frame_req),
    .error_passive    (error_passive),
    .bus_off          (bus_off),
    .tx_drive         (tx_drive),
    .tx_bit           (tx_bit),
    .error_frame_sent (error_frame_sent),
    .form_err_delim   (form_err_delim),
    .stuck_dominant   (stuck_dominant),
    .recovery_done    (recovery_done),
    .busy             (busy),
    .err_frame_cnt    (err_frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_drive(input logic drv, input logic bitv, input logic bsy);
    check("tx_drive", {31'd0, tx_drive}, {31'd0, drv});
    if (drv) check("tx_bit", {31'd0, tx_bit}, {31'd0, bitv});
    check("busy", {31'd0, busy}, {31'd0, bsy});
  endtask

  // One sample point followed by 0..2 tick-free clocks in which no pulse may appear.
  task automatic do_tick(input logic rx, input logic es, input logic ef,
                         input logic sd, input logic rc);
    int gap;
    @(negedge clk);
    rx_bit      = rx;
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    check("error_frame_sent", {31'd0, error_frame_sent}, {31'd0, es});
    check("form_err_delim",   {31'd0, form_err_delim},   {31'd0, ef});
    check("stuck_dominant",   {31'd0, stuck_dominant},   {31'd0, sd});
    check("recovery_done",    {31'd0, recovery_done},    {31'd0, rc});
    if (rc) bus_off = 1'b0;
    gap = int'($urandom_range(0, 2));
    repeat (gap) begin
      @(posedge clk);
      #1;
      check("gap_pulses", {28'd0, error_frame_sent, form_err_delim, stuck_dominant, recovery_done}, 32'd0);
    end
  endtask

  // k_force < 0: random superposition length. p_force > 0: delimiter error at
  // that bit on the first attempt only; p_force < 0: random delimiter errors.
  task automatic run_frame(input logic mode0, input int k_force, input int p_force);
    logic mode;
    logic prev;
    logic b;
    int   k;
    int   p;
    int   run;
    int   n;
    mode            = mode0;
    error_passive   = mode;
    error_frame_req = 1'b1;
    @(posedge clk);
    #1;
    for (int attempt = 0; attempt < 4; attempt++) begin
      if (!mode) begin
        for (int i = 0; i < FLAG_LEN; i++) begin
          expect_drive(1'b1, 1'b0, 1'b1);
          do_tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
        end
      end else begin
        run  = 0;
        n    = 0;
        prev = 1'b1;
        while (run < FLAG_LEN) begin
          if (n == 0 || $urandom_range(0, 3) == 0) b = 1'($urandom_range(0, 1));
          else b = prev;
          if (n > 40) b = prev;
          run  = (n == 0 || b != prev) ? 1 : run + 1;
          prev = b;
          n++;
          expect_drive(1'b1, 1'b1, 1'b1);
          do_tick(b, 1'b0, 1'b0, 1'b0, 1'b0);
        end
      end
      k = (k_force >= 0) ? k_force : int'($urandom_range(0, 30));
      for (int i = 1; i <= k; i++) begin
        expect_drive(1'b1, 1'b1, 1'b1);
        do_tick(1'b0, 1'b0, 1'b0, (i % SUPERPOS_MAX) == 0, 1'b0);
      end
      if (attempt == 0 && p_force > 0) p = p_force;
      else if (p_force < 0 && attempt < 3 && $urandom_range(0, 2) == 0)
        p = int'($urandom_range(2, DELIM_LEN));
      else p = 0;
      for (int bi = 1; bi <= DELIM_LEN; bi++) begin
        expect_drive(1'b1, 1'b1, 1'b1);
        if (bi == p) begin
          mode          = 1'($urandom_range(0, 1));
          error_passive = mode;
          do_tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
          break;
        end
        do_tick(1'b1, bi == DELIM_LEN, 1'b0, 1'b0, 1'b0);
      end
      if (p == 0) break;
    end
    error_frame_req = 1'b0;
    frames++;
    for (int i = 0; i < IFS_LEN; i++) begin
      expect_drive(1'b0, 1'b1, 1'b1);
      do_tick(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("busy_after_ifs", {31'd0, busy}, 32'd0);
  endtask

  task automatic enter_busoff_midflag();
    error_passive   = 1'b0;
    error_frame_req = 1'b1;
    @(posedge clk);
    #1;
    repeat ($urandom_range(1, 4)) begin
      expect_drive(1'b1, 1'b0, 1'b1);
      do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    bus_off         = 1'b1;
    error_frame_req = 1'b0;
    @(posedge clk);
    #1;
    check("busoff_tx_drive", {31'd0, tx_drive}, 32'd0);
    check("busoff_busy", {31'd0, busy}, 32'd1);
  endtask

  // Recovery model: a run of RECOV_BITS recessive bits completes one sequence,
  // a dominant bit restarts the run; RECOV_SEQ sequences complete recovery.
  task automatic run_recovery(input int dom_tick, input logic rnd, output int total);
    int   run;
    int   seqs;
    logic b;
    run   = 0;
    seqs  = 0;
    total = 0;
    while (seqs < RECOV_SEQ && total < 3000) begin
      total++;
      b = 1'b1;
      if (total == dom_tick) b = 1'b0;
      if (rnd && $urandom_range(0, 299) == 0) b = 1'b0;
      if (b) run++;
      else run = 0;
      if (run == RECOV_BITS) begin
        seqs++;
        run = 0;
      end
      expect_drive(1'b0, 1'b1, 1'b1);
      do_tick(b, 1'b0, 1'b0, 1'b0, seqs == RECOV_SEQ);
    end
    check("busy_after_recovery", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int total;
    rst             = 1'b1;
    sample_tick     = 1'b0;
    rx_bit          = 1'b1;
    error_frame_req = 1'b0;
    error_passive   = 1'b0;
    bus_off         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_drive", {31'd0, tx_drive}, 32'd0);
    check("reset_tx_bit", {31'd0, tx_bit}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_pulses", {28'd0, error_frame_sent, form_err_delim, stuck_dominant, recovery_done}, 32'd0);
    check("reset_err_frame_cnt", {16'd0, err_frame_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Active flag, 5 superposition bits, passive flag, 14 bits -> one stuck pulse.
    run_frame(1'b0, 0, 0);
    run_frame(1'b1, 5, 0);
    run_frame(1'b0, 14, 0);
`ifdef ERR_FRAME_STATS_EN
    check("err_frame_cnt_3", {16'd0, err_frame_cnt}, 32'd3);
`else
    check("err_frame_cnt_off", {16'd0, err_frame_cnt}, 32'd0);
`endif

    // Delimiter form error at bit 4, then a clean retry.
    run_frame(1'b0, 2, 4);

    // Asynchronous reset in the middle of a flag.
    error_passive   = 1'b0;
    error_frame_req = 1'b1;
    @(posedge clk);
    #1;
    do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    do_tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_tx_drive", {31'd0, tx_drive}, 32'd0);
    check("midrst_tx_bit", {31'd0, tx_bit}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_err_frame_cnt", {16'd0, err_frame_cnt}, 32'd0);
    error_frame_req = 1'b0;
    frames          = 0;
    @(negedge clk);
    rst = 1'b0;
    run_frame(1'b0, -1, 0);

    // Bus-off mid-flag, recovery with a dominant at bit 7 of sequence 3.
    enter_busoff_midflag();
    run_recovery(2 * RECOV_BITS + 7, 1'b0, total);
    check("recovery_ticks", total, RECOV_SEQ * RECOV_BITS + 7);

    // Bus-off withdrawn before recovery completes.
    enter_busoff_midflag();
    repeat ($urandom_range(5, 40)) begin
      expect_drive(1'b0, 1'b1, 1'b1);
      do_tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    bus_off = 1'b0;
    @(posedge clk);
    #1;
    check("busoff_fall_busy", {31'd0, busy}, 32'd0);
    check("busoff_fall_no_done", {31'd0, recovery_done}, 32'd0);

    // Randomized frames with random superposition and delimiter errors.
    for (int i = 0; i < 12; i++)
      run_frame(1'($urandom_range(0, 1)), -1, -1);

    // Bus-off from IDLE, recovery with random dominant interruptions.
    @(negedge clk);
    bus_off = 1'b1;
    @(posedge clk);
    #1;
    check("idle_busoff_busy", {31'd0, busy}, 32'd1);
    run_recovery(0, 1'b1, total);

    run_frame(1'b1, -1, -1);
`ifdef ERR_FRAME_STATS_EN
    check("err_frame_cnt_final", {16'd0, err_frame_cnt}, frames);
`else
    check("err_frame_cnt_final", {16'd0, err_frame_cnt}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
